flexdpe_fold_acc: RTL and testbench

Parametrised fold accumulator placed after the FAN reduction network of a Flex-DPE. Dot products wider than the PE array are split into several folds. Each fold produces a reduction-output wave, and this block sums those waves per output lane in wide signed accumulators. It emits the completed sums once, after a configurable number of folds, with saturation and error flags. This lets a single DPE handle GEMM tiles whose K dimension exceeds NUM_PES.

---
 rtl/flexdpe_fold_acc.sv | 179 +++++++++++++++++
 tb/tb_flexdpe_fold_acc.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flexdpe_fold_acc.sv
// ---------------------------------------------------------------------------
// flexdpe_fold_acc
//
// Fold accumulator that sits after the FAN reduction network of a Flex-DPE.
// A dot product longer than the PE array is split into several folds. Each
// fold arrives as one reduction-output wave. This block sums the waves per
// output lane in wide signed accumulators. Once the configured number of
// folds has been seen, it emits the completed sums exactly once, with
// saturation and error reporting.
//
// Parameters
//   NUM_PES    number of output lanes
//   DATA_TYPE  width of each incoming signed partial sum
//   ACC_WIDTH  accumulator / output width per lane (>= DATA_TYPE)
//   LOG2_FOLDS width of the fold-count field (folds per tile = num_folds+1)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   i_cfg_valid  request to load i_num_folds
//   i_num_folds  folds per tile minus one
//   i_flush      abort the current tile and discard the accumulators
//   i_valid      per-lane valid from the reduction network
//   i_data_bus   per-lane partial sums, lane n at [n*DATA_TYPE +: DATA_TYPE]
//   o_valid      per-lane result valid, single-cycle pulse
//   o_data_bus   per-lane final sums, lane n at [n*ACC_WIDTH +: ACC_WIDTH]
//   o_fold_cnt   index of the next fold expected in the current tile
//   o_busy       a tile is partially accumulated
//   o_overflow   sticky saturation flag, cleared by an accepted config
//   o_err        one-cycle pulse on a dropped wave or a rejected config
// ---------------------------------------------------------------------------
module flexdpe_fold_acc #(
  parameter int NUM_PES    = 32,
  parameter int DATA_TYPE  = 32,
  parameter int ACC_WIDTH  = 40,
  parameter int LOG2_FOLDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_cfg_valid,
  input  logic [LOG2_FOLDS-1:0]          i_num_folds,
  input  logic                           i_flush,
  input  logic [NUM_PES-1:0]             i_valid,
  input  logic [NUM_PES*DATA_TYPE-1:0]   i_data_bus,
  output logic [NUM_PES-1:0]             o_valid,
  output logic [NUM_PES*ACC_WIDTH-1:0]   o_data_bus,
  output logic [LOG2_FOLDS-1:0]          o_fold_cnt,
  output logic                           o_busy,
  output logic                           o_overflow,
  output logic                           o_err
);

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

  // The extension is at least one bit because the add is done at ACC_WIDTH+1.
  localparam int EXT = ACC_WIDTH + 1 - DATA_TYPE;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [LOG2_FOLDS-1:0] FOLD_ONE = {{(LOG2_FOLDS-1){1'b0}}, 1'b1};

  state_t                  state;
  logic [LOG2_FOLDS-1:0]   num_folds;
  logic [NUM_PES-1:0]      touched;
  logic [ACC_WIDTH-1:0]    acc      [NUM_PES];

  logic [ACC_WIDTH:0]      wide_data [NUM_PES];
  logic [ACC_WIDTH:0]      wide_base [NUM_PES];
  logic [ACC_WIDTH:0]      wide_sum  [NUM_PES];
  logic [ACC_WIDTH-1:0]    acc_sum   [NUM_PES];
  logic [NUM_PES-1:0]      lane_sat;

  logic wave;
  logic first_fold;
  logic final_fold;
  logic cfg_ok;

  assign wave       = |i_valid;
  assign first_fold = (o_fold_cnt == '0);
  assign final_fold = (o_fold_cnt == num_folds);
  // A new fold count may only be loaded between tiles, never alongside a wave,
  // so the count can never fall below a fold index already in flight.
  assign cfg_ok     = i_cfg_valid && !wave && ((state == IDLE) || first_fold);

  // Per-lane saturating add. Fold 0 starts from zero rather than the stale
  // accumulator, which makes back-to-back tiles work without a clear cycle.
  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    for (int n = 0; n < NUM_PES; n++) begin
      wide_data[n] = {{EXT{i_data_bus[n*DATA_TYPE + DATA_TYPE - 1]}},
                      i_data_bus[n*DATA_TYPE +: DATA_TYPE]};
      wide_base[n] = first_fold ? '0 : {acc[n][ACC_WIDTH-1], acc[n]};
      wide_sum[n]  = wide_base[n] + wide_data[n];
      acc_sum[n]   = wide_sum[n][ACC_WIDTH-1:0];
      lane_sat[n]  = 1'b0;
      if (wide_sum[n][ACC_WIDTH] != wide_sum[n][ACC_WIDTH-1]) begin
        acc_sum[n]  = wide_sum[n][ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        lane_sat[n] = i_valid[n];
      end
    end
  end

  // Control FSM and datapath registers. Flush outranks a same-cycle wave and
  // drops it silently. The final wave publishes the updated accumulators for
  // every lane seen in this tile. Lanes never seen drive zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      num_folds  <= '0;
      touched    <= '0;
      o_valid    <= '0;
      o_data_bus <= '0;
      o_fold_cnt <= '0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
      o_err      <= 1'b0;
      for (int n = 0; n < NUM_PES; n++) begin
        acc[n] <= '0;
      end
    end else begin
      o_valid <= '0;
      o_err   <= 1'b0;

      if (cfg_ok) begin
        state      <= ACCUM;
        num_folds  <= i_num_folds;
        o_overflow <= 1'b0;
      end else if (i_cfg_valid) begin
        o_err <= 1'b1;
      end

      if (i_flush) begin
        o_fold_cnt <= '0;
        o_busy     <= 1'b0;
        touched    <= '0;
        for (int n = 0; n < NUM_PES; n++) begin
          acc[n] <= '0;
        end
      end else if (wave) begin
        if (state == IDLE) begin
          o_err <= 1'b1;
        end else begin
          for (int n = 0; n < NUM_PES; n++) begin
            if (i_valid[n]) begin
              acc[n] <= acc_sum[n];
            end else if (first_fold) begin
              acc[n] <= '0;
            end
          end
          if (|lane_sat) begin
            o_overflow <= 1'b1;
          end
          if (final_fold) begin
            o_fold_cnt <= '0;
            o_busy     <= 1'b0;
            touched    <= '0;
            o_valid    <= touched | i_valid;
            for (int n = 0; n < NUM_PES; n++) begin
              if (i_valid[n]) begin
                o_data_bus[n*ACC_WIDTH +: ACC_WIDTH] <= acc_sum[n];
              end else if (touched[n]) begin
                o_data_bus[n*ACC_WIDTH +: ACC_WIDTH] <= acc[n];
              end else begin
                o_data_bus[n*ACC_WIDTH +: ACC_WIDTH] <= '0;
              end
            end
          end else begin
            o_fold_cnt <= o_fold_cnt + FOLD_ONE;
            o_busy     <= 1'b1;
            touched    <= touched | i_valid;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_flexdpe_fold_acc.sv
// ---------------------------------------------------------------------------
// tb_flexdpe_fold_acc
//
// Directed bench for flexdpe_fold_acc. The main instance uses the default
// parameters. A second, narrow instance (ACC_WIDTH == DATA_TYPE == 32) is
// used for the saturation scenario.
// ---------------------------------------------------------------------------
module tb_flexdpe_fold_acc;

  localparam int NP = 32;
  localparam int DW = 32;
  localparam int AW = 40;
  localparam int LF = 4;

  logic clk = 1'b0;
  logic rst_n;

  logic              cfg_valid;
  logic [LF-1:0]     num_folds;
  logic              flush;
  logic [NP-1:0]     valid;
  logic [NP*DW-1:0]  data_bus;
  logic [NP-1:0]     o_valid;
  logic [NP*AW-1:0]  o_data;
  logic [LF-1:0]     fold_cnt;
  logic              busy;
  logic              overflow;
  logic              err;

  logic              b_cfg_valid;
  logic [1:0]        b_num_folds;
  logic              b_flush;
  logic [1:0]        b_valid;
  logic [63:0]       b_data_bus;
  logic [1:0]        b_o_valid;
  logic [63:0]       b_o_data;
  logic [1:0]        b_fold_cnt;
  logic              b_busy;
  logic              b_overflow;
  logic              b_err;

  int compared   = 0;
  int mismatched = 0;

  flexdpe_fold_acc #(
    .NUM_PES(NP), .DATA_TYPE(DW), .ACC_WIDTH(AW), .LOG2_FOLDS(LF)
  ) dut (
    .clk(clk), .rst(rst_n),
    .i_cfg_valid(cfg_valid), .i_num_folds(num_folds), .i_flush(flush),
    .i_valid(valid), .i_data_bus(data_bus),
    .o_valid(o_valid), .o_data_bus(o_data), .o_fold_cnt(fold_cnt),
    .o_busy(busy), .o_overflow(overflow), .o_err(err)
  );

  flexdpe_fold_acc #(
    .NUM_PES(2), .DATA_TYPE(32), .ACC_WIDTH(32), .LOG2_FOLDS(2)
  ) dut_narrow (
    .clk(clk), .rst(rst_n),
    .i_cfg_valid(b_cfg_valid), .i_num_folds(b_num_folds), .i_flush(b_flush),
    .i_valid(b_valid), .i_data_bus(b_data_bus),
    .o_valid(b_o_valid), .o_data_bus(b_o_data), .o_fold_cnt(b_fold_cnt),
    .o_busy(b_busy), .o_overflow(b_overflow), .o_err(b_err)
  );

  always #5 clk = ~clk;

  // Input bus where lane n carries base + step*n.
  function automatic logic [NP*DW-1:0] lanes_in(input int base, input int step);
    logic [NP*DW-1:0] v;
    v = '0;
    for (int n = 0; n < NP; n++) v[n*DW +: DW] = 32'(base + step*n);
    return v;
  endfunction

  // Expected output bus: lane n = base + step*n where mask is set, else 0.
  function automatic logic [NP*AW-1:0] lanes_out(input longint base, input longint step,
                                                 input logic [NP-1:0] mask);
    logic [NP*AW-1:0] v;
    v = '0;
    for (int n = 0; n < NP; n++) if (mask[n]) v[n*AW +: AW] = 40'(base + step*n);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cfg_valid = 1'b0; num_folds = '0; flush = 1'b0; valid = '0; data_bus = '0;
    b_cfg_valid = 1'b0; b_num_folds = '0; b_flush = 1'b0; b_valid = '0; b_data_bus = '0;
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    tick();
    tick();
    compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL reset_valid: got %h expected 0", o_valid); end
    compared++; if (o_data !== '0) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 0", o_data); end
    compared++; if (fold_cnt !== '0) begin mismatched++; $display("[TB] FAIL reset_fold_cnt: got %0d expected 0", fold_cnt); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wave_before_cfg();
    valid = '1; data_bus = lanes_in(1, 0);
    tick();
    compared++; if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL idle_wave_err: got %b expected 1", err); end
    compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL idle_wave_valid: got %h expected 0", o_valid); end
    drive_idle();
    tick();
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_err_pulse: got %b expected 0", err); end
    compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL idle_no_output: got %h expected 0", o_valid); end
  endtask

  task automatic test_basic_fold();
    logic [LF-1:0] exp_cnt;
    cfg_valid = 1'b1; num_folds = 4'd3;
    tick();
    drive_idle();
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_cfg_err: got %b expected 0", err); end
    for (int k = 1; k <= 4; k++) begin
      valid = '1; data_bus = lanes_in(k, 0);
      tick();
      exp_cnt = (k == 4) ? 4'd0 : LF'(k);
      compared++; if (fold_cnt !== exp_cnt) begin mismatched++; $display("[TB] FAIL basic_fold_cnt%0d: got %0d expected %0d", k, fold_cnt, exp_cnt); end
      if (k < 4) begin
        compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL basic_early_valid%0d: got %h expected 0", k, o_valid); end
      end
    end
    compared++; if (o_valid !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL basic_valid: got %h expected ffffffff", o_valid); end
    compared++; if (o_data !== lanes_out(10, 0, '1)) begin mismatched++; $display("[TB] FAIL basic_data: got %h expected %h", o_data, lanes_out(10, 0, '1)); end
    drive_idle();
    tick();
    compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL basic_valid_pulse: got %h expected 0", o_valid); end
    compared++; if (o_data !== lanes_out(10, 0, '1)) begin mismatched++; $display("[TB] FAIL basic_data_hold: got %h expected %h", o_data, lanes_out(10, 0, '1)); end
  endtask

  task automatic test_cfg_mid_tile();
    valid = '1; data_bus = lanes_in(5, 0);
    tick();
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_busy: got %b expected 1", busy); end
    drive_idle();
    cfg_valid = 1'b1; num_folds = 4'd0;
    tick();
    drive_idle();
    compared++; if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_cfg_err: got %b expected 1", err); end
    compared++; if (fold_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL mid_cfg_fold_cnt: got %0d expected 1", fold_cnt); end
    valid = '1; data_bus = lanes_in(5, 0);
    tick();
    compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL mid_cfg_ignored: got %h expected 0", o_valid); end
    compared++; if (fold_cnt !== 4'd2) begin mismatched++; $display("[TB] FAIL mid_fold_cnt2: got %0d expected 2", fold_cnt); end
    tick();
    tick();
    compared++; if (o_valid !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL mid_valid: got %h expected ffffffff", o_valid); end
    compared++; if (o_data !== lanes_out(20, 0, '1)) begin mismatched++; $display("[TB] FAIL mid_data: got %h expected %h", o_data, lanes_out(20, 0, '1)); end
    drive_idle();
    tick();
  endtask

  task automatic test_single_fold();
    logic [NP*AW-1:0] exp_bus;
    cfg_valid = 1'b1; num_folds = 4'd0;
    tick();
    drive_idle();
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL single_cfg_err: got %b expected 0", err); end
    valid = 32'h0000_0020; data_bus = lanes_in(3, 1);
    data_bus[5*DW +: DW] = 32'hFFFF_FFFF;
    tick();
    drive_idle();
    exp_bus = '0;
    exp_bus[5*AW +: AW] = 40'hFF_FFFF_FFFF;
    compared++; if (o_valid !== 32'h0000_0020) begin mismatched++; $display("[TB] FAIL single_valid: got %h expected 00000020", o_valid); end
    compared++; if (o_data !== exp_bus) begin mismatched++; $display("[TB] FAIL single_data: got %h expected %h", o_data, exp_bus); end
    compared++; if (fold_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL single_fold_cnt: got %0d expected 0", fold_cnt); end
    tick();
  endtask

  task automatic test_flush();
    cfg_valid = 1'b1; num_folds = 4'd2;
    tick();
    drive_idle();
    valid = 32'h3; data_bus = lanes_in(100, 0);
    tick();
    valid = 32'h2;
    tick();
    compared++; if (fold_cnt !== 4'd2) begin mismatched++; $display("[TB] FAIL flush_pre_cnt: got %0d expected 2", fold_cnt); end
    drive_idle();
    flush = 1'b1;
    tick();
    drive_idle();
    compared++; if (fold_cnt !== 4'd0) begin mismatched++; $display("[TB] FAIL flush_cnt: got %0d expected 0", fold_cnt); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_busy: got %b expected 0", busy); end
    compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL flush_no_output: got %h expected 0", o_valid); end
    for (int k = 0; k < 3; k++) begin
      valid = 32'h3; data_bus = lanes_in(7, 0);
      tick();
      if (k < 2) begin
        compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL flush_early_valid%0d: got %h expected 0", k, o_valid); end
      end
    end
    drive_idle();
    compared++; if (o_valid !== 32'h3) begin mismatched++; $display("[TB] FAIL flush_valid: got %h expected 00000003", o_valid); end
    compared++; if (o_data !== lanes_out(21, 0, 32'h3)) begin mismatched++; $display("[TB] FAIL flush_data: got %h expected %h", o_data, lanes_out(21, 0, 32'h3)); end
    tick();
  endtask

  task automatic test_back_to_back();
    cfg_valid = 1'b1; num_folds = 4'd1;
    tick();
    drive_idle();
    valid = '1; data_bus = lanes_in(1, 1);
    tick();
    compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL b2b_w1_valid: got %h expected 0", o_valid); end
    data_bus = lanes_in(2, 1);
    tick();
    compared++; if (o_valid !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL b2b_t1_valid: got %h expected ffffffff", o_valid); end
    compared++; if (o_data !== lanes_out(3, 2, '1)) begin mismatched++; $display("[TB] FAIL b2b_t1_data: got %h expected %h", o_data, lanes_out(3, 2, '1)); end
    data_bus = lanes_in(10, 1);
    tick();
    compared++; if (o_valid !== '0) begin mismatched++; $display("[TB] FAIL b2b_w3_valid: got %h expected 0", o_valid); end
    compared++; if (fold_cnt !== 4'd1) begin mismatched++; $display("[TB] FAIL b2b_w3_cnt: got %0d expected 1", fold_cnt); end
    data_bus = lanes_in(20, 1);
    tick();
    drive_idle();
    compared++; if (o_valid !== 32'hFFFF_FFFF) begin mismatched++; $display("[TB] FAIL b2b_t2_valid: got %h expected ffffffff", o_valid); end
    compared++; if (o_data !== lanes_out(30, 2, '1)) begin mismatched++; $display("[TB] FAIL b2b_t2_data: got %h expected %h", o_data, lanes_out(30, 2, '1)); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL main_overflow: got %b expected 0", overflow); end
    tick();
  endtask

  task automatic test_saturation();
    b_cfg_valid = 1'b1; b_num_folds = 2'd1;
    tick();
    drive_idle();
    b_valid = 2'b01; b_data_bus = {32'h0, 32'h7FFF_FFFF};
    tick();
    compared++; if (b_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_early_ovf: got %b expected 0", b_overflow); end
    tick();
    drive_idle();
    compared++; if (b_o_valid !== 2'b01) begin mismatched++; $display("[TB] FAIL sat_pos_valid: got %b expected 01", b_o_valid); end
    compared++; if (b_o_data !== 64'h0000_0000_7FFF_FFFF) begin mismatched++; $display("[TB] FAIL sat_pos_data: got %h expected 000000007fffffff", b_o_data); end
    compared++; if (b_overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_pos_ovf: got %b expected 1", b_overflow); end
    tick();
    tick();
    compared++; if (b_overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL sat_sticky: got %b expected 1", b_overflow); end
    b_valid = 2'b01; b_data_bus = {32'h0, 32'h8000_0000};
    tick();
    tick();
    drive_idle();
    compared++; if (b_o_data !== 64'h0000_0000_8000_0000) begin mismatched++; $display("[TB] FAIL sat_neg_data: got %h expected 0000000080000000", b_o_data); end
    b_cfg_valid = 1'b1; b_num_folds = 2'd1;
    tick();
    drive_idle();
    compared++; if (b_overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_cfg_clear: got %b expected 0", b_overflow); end
    compared++; if (b_err !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_cfg_err: got %b expected 0", b_err); end
  endtask

  initial begin
    test_reset();
    test_wave_before_cfg();
    test_basic_fold();
    test_cfg_mid_tile();
    test_single_fold();
    test_flush();
    test_back_to_back();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
